i2s_tx_serializer: RTL
======================

Name: i2s_tx_serializer

Overview:
- Audio I2S transmit serializer; consumes the LRCLK produced by the existing clock divider (toggles every 25 clk cycles) and the system clk, which is forwarded to the codec as BCLK.
- Accepts stereo sample pairs over a valid/ready handshake and shifts them MSB-first onto sdata in I2S framing (LRCLK low = left).
- Sits between the drum-sample mixer (upstream) and the codec pins (downstream).

Parameters:
- DATA_W, 16, bits per channel sample.
- SLOT_W, 8, width of the per-half-frame slot counter; must hold DATA_W+1.

Ports:
- clk  in  1  system clock; also the codec bit clock.
- rst_n  in  1  reset.
- lrclk  in  1  word-select from the divider, synchronous to clk.
- pair_valid  in  1  upstream has a stereo pair on pair_l/pair_r.
- pair_l  in  DATA_W  left sample, two's complement.
- pair_r  in  DATA_W  right sample, two's complement.
- pair_ready  out  1  holding register empty; transfer when valid & ready on a clk posedge.
- sdata  out  1  serial data to codec.
- underrun  out  1  sticky: a frame started with no pair available.
- underrun_clr  in  1  clears underrun.

Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
- Reset values: sdata=0, pair_ready=1, underrun=0, holding register empty/zero, shift register 0, lrclk_q=0, state IDLE, slot counter 0.
- Edge detect: lrclk_q registers lrclk each cycle. Cycle T is the posedge where lrclk != lrclk_q.
  - Falling edge: lrclk_q=1, lrclk=0.
  - Rising edge: lrclk_q=0, lrclk=1.
- States:
  - IDLE: sdata held 0. Go to LEFT on the first falling edge. Rising edges are ignored, so the output never starts mid-frame.
  - LEFT: entered on a falling edge. Go to RIGHT on a rising edge.
  - RIGHT: entered on a rising edge. Go to LEFT on a falling edge.
- Load at T:
  - Falling edge, holding full: shift register gets the held left word, right word is latched, holding is freed.
  - Falling edge, holding empty: shift register gets 0, right latch gets 0, underrun is set.
  - Rising edge: shift register gets the latched right word.
  - Slot counter reset to 0 at every edge.
- Serial timing (I2S one-bit delay):
  - After posedge T: sdata=0 (delay slot).
  - After posedges T+1 .. T+DATA_W: sdata = bit DATA_W-1 down to 0.
  - After that: sdata=0 until the next edge.
  - With a 25-cycle half-frame and DATA_W=16: slot 0 is delay, slots 1–16 are data, slots 17–24 are zero pad.
- Truncation: if an edge arrives before all bits are sent, the remaining bits are dropped and the new word loads at that edge. No error is flagged.
- Slot counter saturates at its maximum; it never wraps.
- Handshake:
  - pair_ready = holding empty.
  - A transfer fills holding on the next posedge.
  - Holding-free at a falling edge and a new transfer in the same cycle: free takes effect first, the new pair is accepted, and pair_ready goes low again.
  - Upstream must keep pair_l/pair_r stable while valid & !ready.
- underrun:
  - Set on an empty-holding falling edge; otherwise cleared by underrun_clr.
  - Set and clear in the same cycle: set wins.
- Reset mid-frame: all state returns to IDLE immediately (asynchronous). Output resumes only after the next falling edge following deassertion.

Optional Feature:
- I2S_LEFT_JUSTIFIED_EN defined: left-justified format with no delay slot.
  - After posedge T, sdata = bit DATA_W-1 of the new word.
  - Bits DATA_W-1 .. 0 occupy slots 0 .. DATA_W-1; zero pad follows.
- Undefined: standard I2S one-bit delay as above.

Decomposition:
- Package i2s_pkg holds:
  - the DATA_W default;
  - state enum {IDLE, LEFT, RIGHT};
  - slot-count constant DELAY_SLOTS (1, or 0 under I2S_LEFT_JUSTIFIED_EN).
- One sub-module, i2s_tx_shifter: parallel-load, MSB-first shift register with slot counter, padding logic and sdata register.
- Top level keeps edge detect, FSM, holding register, handshake and underrun.

Test Plan:
- Pair L=16'hA5F0, R=16'h0F0F, lrclk from the 25-cycle divider -> LEFT half: sdata 0, then 1010010111110000, then 8 zeros. RIGHT half: 0, then 0000111100001111, then 8 zeros.
- No pair ever supplied -> all-zero sdata; underrun=1 after first falling edge. Pulse underrun_clr -> 0, then re-set at the next falling edge.
- Hold pair_valid=1 with new pairs -> pair_ready low while full, high for exactly 1 cycle at each falling edge, one pair consumed per frame, no drops.
- Release reset while lrclk=1 -> sdata stays 0 through the rising edge. First data after the next falling edge.
- Assert rst_n low at slot 9 of LEFT -> sdata=0 and pair_ready=1 immediately, underrun=0. Recovery as in the previous scenario.
- Build with I2S_LEFT_JUSTIFIED_EN, L=16'h8001 -> sdata=1 in the cycle right after posedge T, data ends at slot 15, zeros in slots 16–24.

Source files
------------

// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared constants and types for the I2S transmit serializer.
//   DATA_W_DEFAULT : default bits per channel sample
//   SLOT_W_DEFAULT : default width of the per-half-frame slot counter
//   state_e        : frame tracking state {IDLE, LEFT, RIGHT}
//   DELAY_SLOTS    : slots between the LRCLK edge and the MSB
// Build option: I2S_LEFT_JUSTIFIED_EN selects left-justified framing
// (MSB in slot 0); when undefined, standard I2S one-bit delay is used.
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int SLOT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_e;

`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam int DELAY_SLOTS = 0;
`else
    localparam int DELAY_SLOTS = 1;
`endif

endpackage

// File: rtl/i2s_tx_shifter.sv
// ---------------------------------------------------------------------------
// i2s_tx_shifter
// Parallel-load, MSB-first shift register with a saturating slot counter,
// zero padding after the last data bit and a registered serial output.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : LRCLK edge this cycle; load word_i and restart the slot count
//   word_i     : word to serialize from this edge
//   run_i      : a frame is in progress (not IDLE); advance slots
//   sdata_o    : registered serial data
// Slot timing follows DELAY_SLOTS from i2s_pkg (I2S_LEFT_JUSTIFIED_EN).
// ---------------------------------------------------------------------------
module i2s_tx_shifter
    import i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int SLOT_W = SLOT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              run_i,
    output logic              sdata_o
);

    localparam logic [SLOT_W-1:0] SLOT_MAX  = '1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DELAY_SLOTS + DATA_W - 1);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [SLOT_W-1:0] slot_next;
    logic              sdata_q, sdata_d;

    // Saturate so a stalled LRCLK can never wrap back into the data window.
    assign slot_next = (slot_q == SLOT_MAX) ? slot_q : slot_q + 1'b1;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        shift_d = shift_q;
        slot_d  = slot_q;
        sdata_d = 1'b0;
        if (load_i) begin
            slot_d = '0;
            if (DELAY_SLOTS == 0) begin
                // Left-justified: MSB goes out in slot 0, directly at the load.
                sdata_d = word_i[DATA_W-1];
                shift_d = word_i << 1;
            end else begin
                shift_d = word_i;
            end
        end else if (run_i) begin
            slot_d = slot_next;
            // slot_next is always >= 1 >= DELAY_SLOTS, so only the upper
            // bound of the data window needs testing; truncation is implicit
            // because a load simply overwrites the remaining bits.
            if (slot_next <= LAST_SLOT) begin
                sdata_d = shift_q[DATA_W-1];
                shift_d = shift_q << 1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            slot_q  <= '0;
            sdata_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            slot_q  <= slot_d;
            sdata_q <= sdata_d;
        end
    end

    assign sdata_o = sdata_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// i2s_tx_serializer
// I2S transmit serializer: takes stereo pairs over valid/ready and shifts
// them MSB-first onto sdata, framed by the divider's LRCLK (low = left).
//   clk          : system clock, forwarded to the codec as BCLK
//   rst_n        : asynchronous active-low reset
//   lrclk        : word select, synchronous to clk
//   pair_valid   : upstream offers pair_l/pair_r
//   pair_l/r     : left/right samples, two's complement
//   pair_ready   : holding register empty
//   sdata        : serial data to codec
//   underrun     : sticky, a frame started with no pair held
//   underrun_clr : clears underrun (a simultaneous set wins)
// Build option: I2S_LEFT_JUSTIFIED_EN (see i2s_pkg) removes the delay slot.
// ---------------------------------------------------------------------------
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int SLOT_W = SLOT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lrclk,
    input  logic              pair_valid,
    input  logic [DATA_W-1:0] pair_l,
    input  logic [DATA_W-1:0] pair_r,
    output logic              pair_ready,
    output logic              sdata,
    output logic              underrun,
    input  logic              underrun_clr
);

    state_e            state_q;
    logic              lrclk_q;
    logic              full_q, full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              underrun_q, underrun_d;
    logic              ready_q, ready_d;

    logic              fall, rise;
    logic              load;
    logic [DATA_W-1:0] load_word;

    assign fall = lrclk_q & ~lrclk;
    assign rise = ~lrclk_q & lrclk;

    always_comb begin
        load       = 1'b0;
        load_word  = '0;
        full_d     = full_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        right_d    = right_q;
        underrun_d = underrun_q;

        if (underrun_clr) underrun_d = 1'b0;

        if (fall) begin
            load = 1'b1;
            if (full_q) begin
                load_word = hold_l_q;
                right_d   = hold_r_q;
                full_d    = 1'b0;
            end else begin
                right_d    = '0;
                underrun_d = 1'b1;  // written after the clear, so set wins
            end
        end else if (rise && state_q != IDLE) begin
            // Rising edges in IDLE are ignored so output never starts mid-frame.
            load      = 1'b1;
            load_word = right_q;
        end

        // Applied after the free above so a same-cycle transfer refills holding.
        if (pair_valid && ready_q) begin
            hold_l_d = pair_l;
            hold_r_d = pair_r;
            full_d   = 1'b1;
        end
    end

    assign ready_d = ~full_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lrclk_q    <= 1'b0;
            full_q     <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            right_q    <= '0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            lrclk_q    <= lrclk;
            full_q     <= full_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            right_q    <= right_d;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
            case (state_q)
                IDLE:    if (fall) state_q <= LEFT;
                LEFT:    if (rise) state_q <= RIGHT;
                RIGHT:   if (fall) state_q <= LEFT;
                default: state_q <= IDLE;
            endcase
        end
    end

    i2s_tx_shifter #(
        .DATA_W (DATA_W),
        .SLOT_W (SLOT_W)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .word_i  (load_word),
        .run_i   (state_q != IDLE),
        .sdata_o (sdata)
    );

    assign pair_ready = ready_q;
    assign underrun   = underrun_q;

endmodule
